sp_bank_reg: RTL and testbench
==============================

Name: sp_bank_reg

Overview:
- Parametrised, multi-bank stack-pointer register; the successor to the single 32-bit load/inc/dec SP.
- Holds NUM_BANKS independent stack pointers (e.g. user/kernel), each with configurable width, step size and reset value.
- Enforces stack limits with sticky overflow/underflow flags. Sits beside the register file and is driven by the control unit on push, pop and SP-load micro-ops.

Parameters:
- WIDTH, 32, data width of each SP and of Din/Dout.
- NUM_BANKS, 2, number of independent SP banks (1..8).
- RESET_VAL, 32'h3fe, reset value of every bank; also the top-of-stack limit.
- LIMIT_LO, 32'h200, lowest legal SP value.
- STEP, 1, amount added or subtracted per inc/dec (1..2^(WIDTH-1)).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- bank_sel  in  max(1,clog2(NUM_BANKS))  selects the bank that ld/inc/dec act on and that Dout shows.
- Din  in  WIDTH  load value.
- ld  in  1  load Din into the selected bank.
- inc  in  1  pop: SP += STEP.
- dec  in  1  push: SP -= STEP.
- clr_flags  in  1  clears the sticky ovf/unf flags.
- Dout  out  WIDTH  SP of the selected bank (combinational mux of registered banks).
- ovf  out  1  sticky: a push was refused because SP - STEP < LIMIT_LO.
- unf  out  1  sticky: a pop was refused because SP + STEP > RESET_VAL.
- fault  out  1  one-cycle pulse on the cycle after any refused op.

Behaviour:
- Reset (reset=0, asynchronous): all banks = RESET_VAL; ovf = unf = fault = 0. On deassertion, state holds until the next clock edge.
- Per clock, only the selected bank may change. Priority is ld > inc > dec; a lower-priority request is ignored in the same cycle.
- ld:
  - bank <= Din unconditionally, with no range check.
  - A subsequent inc/dec is range-checked against the new value.
- inc:
  - Compute SP + STEP in WIDTH+1 bits.
  - If the result is > RESET_VAL: bank holds, unf <= 1, fault pulses next cycle. Otherwise bank <= SP + STEP.
- dec:
  - Compute SP - STEP in WIDTH+1 bits, treating a borrow out as below the limit.
  - If the result is < LIMIT_LO or a borrow occurred: bank holds, ovf <= 1, fault pulses. Otherwise bank <= SP - STEP.
  - SP never wraps modulo 2^WIDTH.
- No request: all banks hold.
- clr_flags:
  - Clears ovf/unf at the next edge.
  - If a refused op occurs in the same cycle, set wins (the flag ends at 1).
- fault is registered, high for exactly one cycle per refused op; back-to-back refusals keep it high.
- bank_sel changes take effect immediately on Dout. The registered state of unselected banks is never disturbed.
- A bank_sel value >= NUM_BANKS is treated as a no-op: no bank updates, Dout = 0, no flags set.
- Latency: an update is visible on Dout one clock after the request.

Optional Feature:
- Macro SP_WATERMARK_EN.
- Defined:
  - Extra output watermark [WIDTH-1:0], per bank, showing the selected bank's lowest SP value ever held since reset.
  - Reset value is RESET_VAL. It updates when the bank's new value is below the current watermark; ld also counts.
  - clr_flags resets the selected bank's watermark to its current SP.
- Undefined: the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package sp_pkg holds:
  - default constants SP_WIDTH, SP_RESET_VAL, SP_LIMIT_LO, SP_STEP;
  - the op encoding typedef sp_op_t (NOP, LD, INC, DEC), resolved by priority.
- Sub-module sp_bank: one SP register, its limit compare and its watermark. It has inputs op and Din and outputs value, ovf_req and unf_req.
- The top level instantiates NUM_BANKS copies via generate and owns the bank decode, output mux, sticky flags and fault register.

Test Plan:
- Reset: assert reset=0 mid-operation with no clock edge -> Dout immediately 32'h3fe in both banks; ovf = unf = fault = 0.
- Push to limit (bank 0): 510 dec cycles -> Dout = 32'h200, no flags. One more dec -> Dout stays 32'h200, ovf = 1, fault high one cycle.
- Pop past top: from reset, inc on bank 1 -> Dout = 32'h3fe, unf = 1. Then clr_flags -> unf = 0. Then clr_flags together with a refused inc -> unf stays 1.
- Priority and isolation:
  - bank 0: ld=inc=dec=1, Din = 32'h300 -> bank 0 = 32'h300.
  - bank 1: dec -> bank 1 = 32'h3fd.
  - Reading bank 0 again -> still 32'h300.
- Wrap guard: parameters LIMIT_LO = 0, STEP = 4, bank loaded with 32'h2, then dec -> holds at 32'h2, ovf = 1 (no wrap to 32'hfffffffe).
- SP_WATERMARK_EN: dec x3 then inc x3 on bank 0 -> Dout = 32'h3fe, watermark = 32'h3fb. clr_flags -> watermark = 32'h3fe.

Source files
------------

// File: rtl/sp_pkg.sv
// sp_pkg: shared constants and op encoding for the banked stack-pointer register
//   SP_WIDTH, SP_RESET_VAL, SP_LIMIT_LO, SP_STEP : default parameters
//   sp_op_t : resolved per-cycle operation (NOP, LD, INC, DEC)
//   sp_resolve : priority encode ld > inc > dec
package sp_pkg;
   localparam int SP_WIDTH = 32;
   localparam logic [31:0] SP_RESET_VAL = 32'h3fe;
   localparam logic [31:0] SP_LIMIT_LO = 32'h200;
   localparam logic [31:0] SP_STEP = 32'd1;
   typedef enum logic [1:0] {NOP, LD, INC, DEC} sp_op_t;
   function automatic sp_op_t sp_resolve(input logic ld, input logic inc, input logic dec);
      return ld ? LD : inc ? INC : dec ? DEC : NOP;
   endfunction
endpackage

// File: rtl/sp_bank.sv
// sp_bank: one stack-pointer register with its limit checks (optional watermark under SP_WATERMARK_EN)
//   clk, reset (async, active-low), op (already gated to this bank), Din (load value)
//   value (current SP), ovf_req / unf_req (this cycle's op is refused)
//   SP_WATERMARK_EN: clr_wm (reload watermark from SP), watermark (lowest SP held)
module sp_bank
   import sp_pkg::*;
#(
   parameter int WIDTH = SP_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(SP_RESET_VAL),
   parameter logic [WIDTH-1:0] LIMIT_LO = WIDTH'(SP_LIMIT_LO),
   parameter logic [WIDTH-1:0] STEP = WIDTH'(SP_STEP)
) (
   input  logic clk,
   input  logic reset,
   input  sp_op_t op,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] value,
   output logic ovf_req,
   output logic unf_req
`ifdef SP_WATERMARK_EN
   ,
   input  logic clr_wm,
   output logic [WIDTH-1:0] watermark
`endif
);
   logic [WIDTH:0] sum, diff;
   logic [WIDTH-1:0] nxt;
   // one extra bit so overflow past the top and borrow below zero are both visible
   assign sum = {1'b0, value} + {1'b0, STEP};
   assign diff = {1'b0, value} - {1'b0, STEP};
   always_comb begin
      unf_req = (op == INC) && (sum > {1'b0, RESET_VAL});
      ovf_req = (op == DEC) && (diff[WIDTH] || diff[WIDTH-1:0] < LIMIT_LO);
      nxt = (op == LD) ? Din :
            (op == INC && !unf_req) ? sum[WIDTH-1:0] :
            (op == DEC && !ovf_req) ? diff[WIDTH-1:0] : value;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) value <= RESET_VAL;
      else value <= nxt;
`ifdef SP_WATERMARK_EN
   logic [WIDTH-1:0] wm_base;
   // a clear restarts tracking from the current SP; any update in the same cycle still counts
   assign wm_base = clr_wm ? value : watermark;
   always_ff @(posedge clk or negedge reset)
      if (!reset) watermark <= RESET_VAL;
      else watermark <= (nxt < wm_base) ? nxt : wm_base;
`endif
endmodule

// File: rtl/sp_bank_reg.sv
// sp_bank_reg: multi-bank stack pointer with sticky limit flags (optional watermark under SP_WATERMARK_EN)
//   clk, reset (async, active-low), bank_sel, Din, ld/inc/dec (priority ld > inc > dec), clr_flags
//   Dout (selected SP, 0 for an invalid bank), ovf/unf (sticky refusals), fault (pulse after a refusal)
//   SP_WATERMARK_EN: watermark (selected bank's lowest SP since reset or clear)
module sp_bank_reg
   import sp_pkg::*;
#(
   parameter int WIDTH = SP_WIDTH,
   parameter int NUM_BANKS = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(SP_RESET_VAL),
   parameter logic [WIDTH-1:0] LIMIT_LO = WIDTH'(SP_LIMIT_LO),
   parameter logic [WIDTH-1:0] STEP = WIDTH'(SP_STEP),
   localparam int SW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1
) (
   input  logic clk,
   input  logic reset,
   input  logic [SW-1:0] bank_sel,
   input  logic [WIDTH-1:0] Din,
   input  logic ld,
   input  logic inc,
   input  logic dec,
   input  logic clr_flags,
   output logic [WIDTH-1:0] Dout,
   output logic ovf,
   output logic unf,
   output logic fault
`ifdef SP_WATERMARK_EN
   ,
   output logic [WIDTH-1:0] watermark
`endif
);
   sp_op_t op;
   logic sel_ok;
   logic [WIDTH-1:0] vals [NUM_BANKS];
   logic [NUM_BANKS-1:0] ovf_reqs, unf_reqs;
`ifdef SP_WATERMARK_EN
   logic [WIDTH-1:0] wms [NUM_BANKS];
   assign watermark = sel_ok ? wms[bank_sel] : '0;
`endif
   assign op = sp_resolve(ld, inc, dec);
   // out-of-range selects touch nothing and read as zero
   assign sel_ok = {1'b0, bank_sel} < (SW + 1)'(NUM_BANKS);
   assign Dout = sel_ok ? vals[bank_sel] : '0;
   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic hit;
      sp_op_t bop;
      assign hit = sel_ok && bank_sel == SW'(g);
      assign bop = hit ? op : NOP;
      sp_bank #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL), .LIMIT_LO(LIMIT_LO), .STEP(STEP)) u_bank (
         .clk(clk),
         .reset(reset),
         .op(bop),
         .Din(Din),
         .value(vals[g]),
         .ovf_req(ovf_reqs[g]),
         .unf_req(unf_reqs[g])
`ifdef SP_WATERMARK_EN
         ,
         .clr_wm(hit && clr_flags),
         .watermark(wms[g])
`endif
      );
   end
   // a refusal in the same cycle as a clear wins
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ovf <= 1'b0;
         unf <= 1'b0;
         fault <= 1'b0;
      end else begin
         ovf <= |ovf_reqs || (ovf && !clr_flags);
         unf <= |unf_reqs || (unf && !clr_flags);
         fault <= |ovf_reqs || |unf_reqs;
      end
endmodule

// File: tb/tb_sp_bank_reg.sv
// tb_sp_bank_reg: table-driven, directed and randomized checks of sp_bank_reg
module tb_sp_bank_reg;
   logic clk = 1'b0;
   logic reset;
   logic [0:0] bank_sel, w_sel;
   logic [31:0] Din, Dout, w_din, w_dout;
   logic ld, inc, dec, clr_flags, ovf, unf, fault;
   logic w_ld, w_inc, w_dec, w_clr, w_ovf, w_unf, w_fault;
`ifdef SP_WATERMARK_EN
   logic [31:0] watermark, w_wm;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sp_bank_reg u_dut (
      .clk(clk), .reset(reset), .bank_sel(bank_sel), .Din(Din), .ld(ld), .inc(inc), .dec(dec),
      .clr_flags(clr_flags), .Dout(Dout), .ovf(ovf), .unf(unf), .fault(fault)
`ifdef SP_WATERMARK_EN
      , .watermark(watermark)
`endif
   );

   sp_bank_reg #(.NUM_BANKS(1), .LIMIT_LO(32'h0), .STEP(32'd4)) u_wrap (
      .clk(clk), .reset(reset), .bank_sel(w_sel), .Din(w_din), .ld(w_ld), .inc(w_inc), .dec(w_dec),
      .clr_flags(w_clr), .Dout(w_dout), .ovf(w_ovf), .unf(w_unf), .fault(w_fault)
`ifdef SP_WATERMARK_EN
      , .watermark(w_wm)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic [31:0] d, input logic l, input logic i, input logic de, input logic c);
      bank_sel = s; Din = d; ld = l; inc = i; dec = de; clr_flags = c;
      @(posedge clk); #1;
      ld = 0; inc = 0; dec = 0; clr_flags = 0;
   endtask

   task automatic wcyc(input logic s, input logic [31:0] d, input logic l, input logic i, input logic de);
      w_sel = s; w_din = d; w_ld = l; w_inc = i; w_dec = de;
      @(posedge clk); #1;
      w_ld = 0; w_inc = 0; w_dec = 0;
   endtask

   task automatic do_reset();
      reset = 0;
      @(posedge clk); #1;
      reset = 1;
   endtask

   // reference model: plain integer arithmetic on unbounded values
   localparam longint RV = 'h3fe, LO = 'h200, ST = 1;
   longint m[2];
   bit m_ovf, m_unf, m_fault;

   task automatic model_reset();
      m[0] = RV; m[1] = RV; m_ovf = 0; m_unf = 0; m_fault = 0;
   endtask

   task automatic model_step(input int sel, input longint din, input bit l, input bit i, input bit d, input bit c);
      bit ro = 0, ru = 0;
      if (sel < 2) begin
         if (l) m[sel] = din;
         else if (i) begin
            if (m[sel] + ST > RV) ru = 1; else m[sel] = m[sel] + ST;
         end else if (d) begin
            if (m[sel] - ST < LO) ro = 1; else m[sel] = m[sel] - ST;
         end
      end
      m_ovf = ro | (m_ovf & !c);
      m_unf = ru | (m_unf & !c);
      m_fault = ro | ru;
   endtask

   typedef struct {
      logic s; logic [31:0] d; logic l, i, de, c;
      logic [31:0] eo; logic ov, un, fa;
   } vec_t;
   vec_t tbl[14];

   initial begin
      tbl[0]  = '{1'b0, 32'h300, 1, 1, 1, 0, 32'h300, 0, 0, 0};
      tbl[1]  = '{1'b1, 32'h0,   0, 0, 1, 0, 32'h3fd, 0, 0, 0};
      tbl[2]  = '{1'b0, 32'h0,   0, 0, 0, 0, 32'h300, 0, 0, 0};
      tbl[3]  = '{1'b1, 32'h0,   0, 1, 0, 0, 32'h3fe, 0, 0, 0};
      tbl[4]  = '{1'b1, 32'h0,   0, 1, 0, 0, 32'h3fe, 0, 1, 1};
      tbl[5]  = '{1'b1, 32'h0,   0, 0, 0, 0, 32'h3fe, 0, 1, 0};
      tbl[6]  = '{1'b1, 32'h0,   0, 0, 0, 1, 32'h3fe, 0, 0, 0};
      tbl[7]  = '{1'b1, 32'h0,   0, 1, 0, 1, 32'h3fe, 0, 1, 1};
      tbl[8]  = '{1'b0, 32'h200, 1, 0, 0, 1, 32'h200, 0, 0, 0};
      tbl[9]  = '{1'b0, 32'h0,   0, 0, 1, 0, 32'h200, 1, 0, 1};
      tbl[10] = '{1'b0, 32'h0,   0, 0, 1, 0, 32'h200, 1, 0, 1};
      tbl[11] = '{1'b0, 32'h5,   1, 0, 0, 0, 32'h5,   1, 0, 0};
      tbl[12] = '{1'b0, 32'h0,   0, 1, 0, 0, 32'h6,   1, 0, 0};
      tbl[13] = '{1'b1, 32'h0,   0, 0, 0, 1, 32'h3fe, 0, 0, 0};
      bank_sel = 0; Din = 0; ld = 0; inc = 0; dec = 0; clr_flags = 0;
      w_sel = 0; w_din = 0; w_ld = 0; w_inc = 0; w_dec = 0; w_clr = 0;
      reset = 0;
      #12;
      chk("reset_dout", Dout, 32'h3fe);
      chk("reset_flags", {29'd0, ovf, unf, fault}, 32'd0);
      @(posedge clk); #1;
      reset = 1;

      foreach (tbl[k]) begin
         cyc(tbl[k].s, tbl[k].d, tbl[k].l, tbl[k].i, tbl[k].de, tbl[k].c);
         chk($sformatf("vec%0d_dout", k), Dout, tbl[k].eo);
         chk($sformatf("vec%0d_flags", k), {29'd0, ovf, unf, fault}, {29'd0, tbl[k].ov, tbl[k].un, tbl[k].fa});
      end

      // async reset mid-operation, checked before any clock edge
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 0);
      bank_sel = 0; dec = 1;
      @(posedge clk); #3;
      reset = 0; #1;
      chk("async_rst_b0", Dout, 32'h3fe);
      bank_sel = 1; #1;
      chk("async_rst_b1", Dout, 32'h3fe);
      chk("async_rst_flags", {29'd0, ovf, unf, fault}, 32'd0);
      dec = 0;
      @(posedge clk); #1;
      reset = 1;

      // push bank 0 down to the lower limit, then one past it
      for (int n = 0; n < 510; n++) cyc(0, 0, 0, 0, 1, 0);
      chk("limit_dout", Dout, 32'h200);
      chk("limit_flags", {29'd0, ovf, unf, fault}, 32'd0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("limit_hold", Dout, 32'h200);
      chk("limit_ovf_fault", {29'd0, ovf, unf, fault}, 32'b101);
      cyc(0, 0, 0, 0, 0, 0);
      chk("limit_fault_drop", {29'd0, ovf, unf, fault}, 32'b100);

      // small-limit, large-step instance: no wrap below zero, invalid select is inert
      wcyc(0, 32'h2, 1, 0, 0);
      chk("wrap_ld", w_dout, 32'h2);
      wcyc(0, 0, 0, 0, 1);
      chk("wrap_hold", w_dout, 32'h2);
      chk("wrap_flags", {29'd0, w_ovf, w_unf, w_fault}, 32'b101);
      wcyc(1, 32'h55, 1, 0, 1);
      chk("badsel_dout", w_dout, 32'h0);
      chk("badsel_flags", {29'd0, w_ovf, w_unf, w_fault}, 32'b100);
      w_sel = 0; #1;
      chk("badsel_untouched", w_dout, 32'h2);
      wcyc(0, 0, 0, 1, 0);
      chk("wrap_inc", w_dout, 32'h6);

      // randomized run against the model
      do_reset();
      model_reset();
      for (int n = 0; n < 400; n++) begin
         int s, pick;
         longint d;
         bit l, i, de, c;
         s = $urandom_range(0, 1);
         pick = $urandom_range(0, 2);
         d = pick == 0 ? LO + $urandom_range(0, 3) : pick == 1 ? RV - $urandom_range(0, 3) : longint'($urandom_range(LO, RV));
         l = $urandom_range(0, 7) == 0;
         i = $urandom_range(0, 1);
         de = $urandom_range(0, 1);
         c = $urandom_range(0, 7) == 0;
         cyc(s[0], d[31:0], l, i, de, c);
         model_step(s, d, l, i, de, c);
         chk($sformatf("rnd%0d_dout", n), Dout, m[s][31:0]);
         chk($sformatf("rnd%0d_flags", n), {29'd0, ovf, unf, fault}, {29'd0, m_ovf, m_unf, m_fault});
      end

`ifdef SP_WATERMARK_EN
      do_reset();
      for (int n = 0; n < 3; n++) cyc(0, 0, 0, 0, 1, 0);
      for (int n = 0; n < 3; n++) cyc(0, 0, 0, 1, 0, 0);
      chk("wm_dout", Dout, 32'h3fe);
      chk("wm_low", watermark, 32'h3fb);
      cyc(0, 0, 0, 0, 0, 1);
      chk("wm_clr", watermark, 32'h3fe);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
